// File: rtl/scaler_ctrl.sv
// scaler_ctrl: crop-window sequencer for the DVP stream scaler.
// Converts a crop window into input resolutions and Q4.14 scale factors using
// one shared restoring divider, validates the result, and commits it only on a
// rising edge of vs_in so the scaler geometry never changes mid-frame.
// Optional feature macro: SCALER_CTRL_AUTO_BYPASS_EN (a 1:1 geometry clears scaler_en).

module scaler_ctrl #(
  parameter int RES_WIDTH  = 11,
  parameter int OUT_X_RES  = 1280,
  parameter int OUT_Y_RES  = 720,
  parameter int SCALE_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic                  cfg_en,
  input  logic [RES_WIDTH-1:0]  cfg_start_x,
  input  logic [RES_WIDTH-1:0]  cfg_start_y,
  input  logic [RES_WIDTH-1:0]  cfg_end_x,
  input  logic [RES_WIDTH-1:0]  cfg_end_y,
  input  logic                  vs_in,
  output logic                  busy,
  output logic                  cfg_pending,
  output logic                  cfg_err,
  output logic                  scaler_start,
  output logic                  scaler_en,
  output logic [RES_WIDTH-1:0]  in_x_res,
  output logic [RES_WIDTH-1:0]  in_y_res,
  output logic [SCALE_BITS-1:0] x_scale,
  output logic [SCALE_BITS-1:0] y_scale
);

  // Widths are computed one bit wider than coordinates so end < start cannot
  // silently alias onto a small positive width.
  localparam int FRAC_BITS = 14;
  localparam int W_W       = RES_WIDTH + 1;
  localparam int NUM_W     = W_W + FRAC_BITS;   // numerator and quotient width
  localparam int REM_W     = W_W + 1;           // shifted partial remainder width
  localparam int CNT_W     = 5;

  localparam logic [REM_W-1:0]      DIV_X_C   = REM_W'(OUT_X_RES);
  localparam logic [REM_W-1:0]      DIV_Y_C   = REM_W'(OUT_Y_RES);
  localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(NUM_W - 1);
  localparam logic [SCALE_BITS-1:0] UNITY     = SCALE_BITS'(1 << FRAC_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIV_X = 3'd1,
    S_DIV_Y = 3'd2,
    S_CHECK = 3'd3,
    S_PEND  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched request
  logic                 r_cfg_en;
  logic [RES_WIDTH-1:0] r_start_x;
  logic [RES_WIDTH-1:0] r_start_y;
  logic [RES_WIDTH-1:0] r_end_x;
  logic [RES_WIDTH-1:0] r_end_y;

  // Divider state
  logic [CNT_W-1:0] r_cnt;
  logic [REM_W-2:0] r_rem;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-2:0] r_quo;
  logic [NUM_W-1:0] r_qx;
  logic [NUM_W-1:0] r_qy;

  // Frame sync and committed outputs
  logic                  r_vs_prev;
  logic                  r_scaler_start;
  logic                  r_cfg_err;
  logic                  r_scaler_en;
  logic [RES_WIDTH-1:0]  r_in_x_res;
  logic [RES_WIDTH-1:0]  r_in_y_res;
  logic [SCALE_BITS-1:0] r_x_scale;
  logic [SCALE_BITS-1:0] r_y_scale;

  // Combinational helpers
  logic [W_W-1:0]       w_cfg_in_w;
  logic [W_W-1:0]       w_in_w;
  logic [W_W-1:0]       w_in_h;
  logic [RES_WIDTH-1:0] w_x_res_m1;
  logic [RES_WIDTH-1:0] w_y_res_m1;
  logic                 w_x_bad;
  logic                 w_y_bad;
  logic                 w_ovf;
  logic                 w_err;
  logic                 w_vs_rise;
  logic                 w_commit;
  logic                 w_set_err;
  logic                 w_en_commit;
  logic [REM_W-1:0]     w_divisor;
  logic [REM_W-1:0]     w_rem_shift;
  logic                 w_qbit;
  logic [REM_W-2:0]     w_rem_next;
  logic                 w_div_last;

  // The X numerator is loaded straight from the inputs on cfg_wr so the first
  // quotient bit can be produced on the very next cycle.
  assign w_cfg_in_w = {1'b0, cfg_end_x} - {1'b0, cfg_start_x};
  assign w_in_w     = {1'b0, r_end_x} - {1'b0, r_start_x};
  assign w_in_h     = {1'b0, r_end_y} - {1'b0, r_start_y};
  assign w_x_res_m1 = w_in_w[RES_WIDTH-1:0] - RES_WIDTH'(1);
  assign w_y_res_m1 = w_in_h[RES_WIDTH-1:0] - RES_WIDTH'(1);

  // A window needs at least two pixels/lines; end <= start+1 also catches end < start.
  assign w_x_bad = ({1'b0, r_end_x} <= ({1'b0, r_start_x} + W_W'(1)));
  assign w_y_bad = ({1'b0, r_end_y} <= ({1'b0, r_start_y} + W_W'(1)));
  assign w_ovf   = (|r_qx[NUM_W-1:SCALE_BITS]) | (|r_qy[NUM_W-1:SCALE_BITS]);
  assign w_err   = w_x_bad | w_y_bad | w_ovf;

  // One restoring-divide step: bring down the next numerator bit, subtract if it fits.
  assign w_divisor   = (r_state == S_DIV_Y) ? DIV_Y_C : DIV_X_C;
  assign w_rem_shift = {r_rem, r_num[NUM_W-1]};
  assign w_qbit      = (w_rem_shift >= w_divisor);
  assign w_rem_next  = (REM_W-1)'(w_qbit ? (w_rem_shift - w_divisor) : w_rem_shift);
  assign w_div_last  = (r_cnt == LAST_STEP);

  assign w_vs_rise = vs_in & ~r_vs_prev;

`ifdef SCALER_CTRL_AUTO_BYPASS_EN
  // Exact 1:1 geometry needs no resampling, so the scaler is bypassed.
  assign w_en_commit = r_cfg_en &
                       ~((w_in_w == W_W'(OUT_X_RES)) && (w_in_h == W_W'(OUT_Y_RES)));
`else
  assign w_en_commit = r_cfg_en;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and commit/error strobes; a new request always restarts.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
      end
      S_DIV_X: begin
        if (w_div_last) begin
          w_state_next = S_DIV_Y;
        end
      end
      S_DIV_Y: begin
        if (w_div_last) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_err) begin
          w_state_next = S_IDLE;
          w_set_err    = 1'b1;
        end else begin
          w_state_next = S_PEND;
        end
      end
      S_PEND: begin
        if (w_vs_rise) begin
          w_state_next = S_IDLE;
          w_commit     = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (cfg_wr) begin
      w_state_next = S_DIV_X;
      w_commit     = 1'b0;
      w_set_err    = 1'b0;
    end
  end

  // Request latch and shared divider datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_en  <= 1'b0;
      r_start_x <= '0;
      r_start_y <= '0;
      r_end_x   <= '0;
      r_end_y   <= '0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_num     <= '0;
      r_quo     <= '0;
      r_qx      <= '0;
      r_qy      <= '0;
    end else if (cfg_wr) begin
      r_cfg_en  <= cfg_en;
      r_start_x <= cfg_start_x;
      r_start_y <= cfg_start_y;
      r_end_x   <= cfg_end_x;
      r_end_y   <= cfg_end_y;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_num     <= {w_cfg_in_w, {FRAC_BITS{1'b0}}};
    end else if ((r_state == S_DIV_X) || (r_state == S_DIV_Y)) begin
      if (w_div_last) begin
        // Final bit: capture the full quotient and prime the Y numerator.
        if (r_state == S_DIV_X) begin
          r_qx <= {r_quo, w_qbit};
        end else begin
          r_qy <= {r_quo, w_qbit};
        end
        r_cnt <= '0;
        r_rem <= '0;
        r_quo <= '0;
        r_num <= {w_in_h, {FRAC_BITS{1'b0}}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_rem <= w_rem_next;
        r_quo <= {r_quo[NUM_W-3:0], w_qbit};
        r_num <= {r_num[NUM_W-2:0], 1'b0};
      end
    end
  end

  // Frame-edge detection, sticky error and committed geometry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev      <= 1'b0;
      r_scaler_start <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_scaler_en    <= 1'b0;
      r_in_x_res     <= RES_WIDTH'(OUT_X_RES - 1);
      r_in_y_res     <= RES_WIDTH'(OUT_Y_RES - 1);
      r_x_scale      <= UNITY;
      r_y_scale      <= UNITY;
    end else begin
      r_vs_prev      <= vs_in;
      r_scaler_start <= w_vs_rise;
      if (cfg_wr) begin
        r_cfg_err <= 1'b0;
      end else if (w_set_err) begin
        r_cfg_err <= 1'b1;
      end
      if (w_commit) begin
        r_scaler_en <= w_en_commit;
        r_in_x_res  <= w_x_res_m1;
        r_in_y_res  <= w_y_res_m1;
        r_x_scale   <= r_qx[SCALE_BITS-1:0];
        r_y_scale   <= r_qy[SCALE_BITS-1:0];
      end
    end
  end

  assign busy         = (r_state == S_DIV_X) || (r_state == S_DIV_Y) || (r_state == S_CHECK);
  assign cfg_pending  = (r_state == S_PEND);
  assign cfg_err      = r_cfg_err;
  assign scaler_start = r_scaler_start;
  assign scaler_en    = r_scaler_en;
  assign in_x_res     = r_in_x_res;
  assign in_y_res     = r_in_y_res;
  assign x_scale      = r_x_scale;
  assign y_scale      = r_y_scale;

endmodule

// File: tb/tb_scaler_ctrl.sv
// tb_scaler_ctrl: scoreboard bench for scaler_ctrl.
// Expected committed geometry is pushed when a frame edge is driven and is
// popped and compared when the DUT answers with scaler_start.
// Honours SCALER_CTRL_AUTO_BYPASS_EN for the expected scaler_en.

module tb_scaler_ctrl;

  localparam int RW = 11;
  localparam int OX = 1280;
  localparam int OY = 720;
  localparam int SB = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_wr = 1'b0;
  logic          cfg_en = 1'b0;
  logic [RW-1:0] cfg_start_x = '0;
  logic [RW-1:0] cfg_start_y = '0;
  logic [RW-1:0] cfg_end_x = '0;
  logic [RW-1:0] cfg_end_y = '0;
  logic          vs_in = 1'b0;
  logic          busy;
  logic          cfg_pending;
  logic          cfg_err;
  logic          scaler_start;
  logic          scaler_en;
  logic [RW-1:0] in_x_res;
  logic [RW-1:0] in_y_res;
  logic [SB-1:0] x_scale;
  logic [SB-1:0] y_scale;

  scaler_ctrl #(
    .RES_WIDTH (RW),
    .OUT_X_RES (OX),
    .OUT_Y_RES (OY),
    .SCALE_BITS(SB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_wr      (cfg_wr),
    .cfg_en      (cfg_en),
    .cfg_start_x (cfg_start_x),
    .cfg_start_y (cfg_start_y),
    .cfg_end_x   (cfg_end_x),
    .cfg_end_y   (cfg_end_y),
    .vs_in       (vs_in),
    .busy        (busy),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err),
    .scaler_start(scaler_start),
    .scaler_en   (scaler_en),
    .in_x_res    (in_x_res),
    .in_y_res    (in_y_res),
    .x_scale     (x_scale),
    .y_scale     (y_scale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] xres;
    logic [RW-1:0] yres;
    logic [SB-1:0] xs;
    logic [SB-1:0] ys;
    logic          en;
  } commit_t;

  commit_t sb_q[$];
  commit_t model_cur;
  commit_t model_pend;
  commit_t model_next;
  bit      model_pend_valid = 1'b0;
  bit      model_next_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  function automatic commit_t reset_commit();
    commit_t c;
    c.xres = RW'(OX - 1);
    c.yres = RW'(OY - 1);
    c.xs   = 18'h04000;
    c.ys   = 18'h04000;
    c.en   = 1'b0;
    return c;
  endfunction

  // Reference model: plain integer arithmetic straight from the geometry.
  function automatic commit_t calc(input int sx, input int sy, input int ex, input int ey,
                                   input bit en);
    commit_t c;
    int w;
    int h;
    w = ex - sx;
    h = ey - sy;
    c.xres = RW'(w - 1);
    c.yres = RW'(h - 1);
    c.xs   = SB'((w * 16384) / OX);
    c.ys   = SB'((h * 16384) / OY);
`ifdef SCALER_CTRL_AUTO_BYPASS_EN
    c.en   = en && !((w == OX) && (h == OY));
`else
    c.en   = en;
`endif
    return c;
  endfunction

  function automatic commit_t observed();
    commit_t c;
    c.xres = in_x_res;
    c.yres = in_y_res;
    c.xs   = x_scale;
    c.ys   = y_scale;
    c.en   = scaler_en;
    return c;
  endfunction

  // Drive a one-cycle cfg_wr; returns at the negedge of cycle 1 after the write edge.
  task automatic cfg_write(input int sx, input int sy, input int ex, input int ey, input bit en);
    cfg_start_x = RW'(sx);
    cfg_start_y = RW'(sy);
    cfg_end_x   = RW'(ex);
    cfg_end_y   = RW'(ey);
    cfg_en      = en;
    cfg_wr      = 1'b1;
    model_next       = calc(sx, sy, ex, ey, en);
    model_next_valid = (ex > sx + 1) && (ey > sy + 1);
    model_pend_valid = 1'b0;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  // Bounded wait for the computation to finish, then check the verdict against the model.
  task automatic wait_done(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (cfg_pending || cfg_err) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0b err=%0b after 80 cycles, required completion",
               tag, cfg_pending, cfg_err);
    end
    total++;
    if (cfg_pending !== model_next_valid || cfg_err !== !model_next_valid || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_verdict: pending=%0b err=%0b busy=%0b, required pending=%0b err=%0b busy=0",
               tag, cfg_pending, cfg_err, busy, model_next_valid, !model_next_valid);
    end
    if (model_next_valid) begin
      model_pend       = model_next;
      model_pend_valid = 1'b1;
    end
  endtask

  // Drive a vs_in rising edge, hold it high, and pop/compare on scaler_start.
  task automatic vs_edge(input string tag);
    commit_t exp;
    commit_t obs;
    if (model_pend_valid) begin
      model_cur        = model_pend;
      model_pend_valid = 1'b0;
    end
    sb_q.push_back(model_cur);
    vs_in = 1'b1;
    @(negedge clk);
    total++;
    if (scaler_start !== 1'b1) begin
      bad++;
      $display("FAIL %s_start: scaler_start=%0b, required 1", tag, scaler_start);
    end
    exp = sb_q.pop_front();
    obs = observed();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s_commit: got xres=%0d yres=%0d xs=%h ys=%h en=%0b, required xres=%0d yres=%0d xs=%h ys=%h en=%0b",
               tag, obs.xres, obs.yres, obs.xs, obs.ys, obs.en,
               exp.xres, exp.yres, exp.xs, exp.ys, exp.en);
    end
    $display("frame %s: xres=%0d yres=%0d xs=%h ys=%h en=%0b",
             tag, obs.xres, obs.yres, obs.xs, obs.ys, obs.en);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (scaler_start !== 1'b0) begin
        bad++;
        $display("FAIL %s_hold%0d: scaler_start=%0b while vs_in held high, required 0",
                 tag, i, scaler_start);
      end
    end
    vs_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if (busy !== 1'b0 || cfg_pending !== 1'b0 || cfg_err !== 1'b0 || scaler_start !== 1'b0) begin
      bad++;
      $display("FAIL %s_flags: busy=%0b pending=%0b err=%0b start=%0b, required all 0",
               tag, busy, cfg_pending, cfg_err, scaler_start);
    end
    total++;
    if (observed() !== reset_commit()) begin
      bad++;
      $display("FAIL %s_geom: got xres=%0d yres=%0d xs=%h ys=%h en=%0b, required 1279 719 04000 04000 0",
               tag, in_x_res, in_y_res, x_scale, y_scale, scaler_en);
    end
  endtask

  task automatic test_reset();
    model_cur = reset_commit();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (scaler_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_nostart%0d: scaler_start=%0b without vs edge, required 0", i, scaler_start);
      end
    end
    vs_edge("reset_frame");
  endtask

  // Exact latency: busy over cycles 1..53, pending on cycle 54.
  task automatic test_basic();
    int bad_cycles;
    cfg_write(0, 0, 640, 360, 1'b1);
    bad_cycles = 0;
    for (int c = 1; c <= 53; c++) begin
      if (busy !== 1'b1 || cfg_pending !== 1'b0) begin
        bad_cycles++;
        if (bad_cycles == 1)
          $display("FAIL basic_busy_c%0d: busy=%0b pending=%0b, required busy=1 pending=0",
                   c, busy, cfg_pending);
      end
      @(negedge clk);
    end
    total++;
    if (bad_cycles != 0) bad++;
    total++;
    if (busy !== 1'b0 || cfg_pending !== 1'b1) begin
      bad++;
      $display("FAIL basic_pend_c54: busy=%0b pending=%0b, required busy=0 pending=1",
               busy, cfg_pending);
    end
    model_pend       = model_next;
    model_pend_valid = model_next_valid;
    vs_edge("basic_640x360");
  endtask

  task automatic test_unity();
    cfg_write(0, 0, 1280, 720, 1'b1);
    wait_done("unity");
    vs_edge("unity_1280x720");
  endtask

  task automatic test_invalid();
    cfg_write(100, 0, 101, 720, 1'b1);
    wait_done("invalid");
    vs_edge("invalid_kept");
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL invalid_sticky: cfg_err=%0b after frame edge, required 1", cfg_err);
    end
    cfg_write(0, 0, 320, 180, 1'b1);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL invalid_clear: cfg_err=%0b after new cfg_wr, required 0", cfg_err);
    end
    wait_done("after_invalid");
    vs_edge("quarter_320x180");
  endtask

  task automatic test_vs_mid_div();
    cfg_write(0, 0, 960, 540, 1'b1);
    repeat (19) @(negedge clk);
    vs_edge("middiv_old");
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL middiv_busy: busy=%0b after mid-division edge, required 1", busy);
    end
    wait_done("middiv");
    vs_edge("middiv_960x540");
  endtask

  // Restart and frame edge in the same cycle while PEND: restart wins, no commit.
  task automatic test_back_to_back();
    commit_t exp;
    commit_t obs;
    cfg_write(0, 0, 640, 360, 1'b1);
    wait_done("b2b_first");
    cfg_start_x = RW'(100);
    cfg_start_y = RW'(20);
    cfg_end_x   = RW'(1124);
    cfg_end_y   = RW'(596);
    cfg_en      = 1'b1;
    cfg_wr      = 1'b1;
    vs_in       = 1'b1;
    model_next       = calc(100, 20, 1124, 596, 1'b1);
    model_next_valid = 1'b1;
    model_pend_valid = 1'b0;
    sb_q.push_back(model_cur);
    @(negedge clk);
    cfg_wr = 1'b0;
    total++;
    if (scaler_start !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start: scaler_start=%0b, required 1", scaler_start);
    end
    exp = sb_q.pop_front();
    obs = observed();
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL b2b_nocommit: got xres=%0d yres=%0d xs=%h ys=%h en=%0b, required xres=%0d yres=%0d xs=%h ys=%h en=%0b",
               obs.xres, obs.yres, obs.xs, obs.ys, obs.en,
               exp.xres, exp.yres, exp.xs, exp.ys, exp.en);
    end
    $display("frame b2b_restart: xres=%0d yres=%0d xs=%h ys=%h en=%0b",
             obs.xres, obs.yres, obs.xs, obs.ys, obs.en);
    total++;
    if (busy !== 1'b1 || cfg_pending !== 1'b0) begin
      bad++;
      $display("FAIL b2b_restart: busy=%0b pending=%0b, required busy=1 pending=0", busy, cfg_pending);
    end
    @(negedge clk);
    vs_in = 1'b0;
    wait_done("b2b_second");
    vs_edge("b2b_1024x576");
  endtask

  // Asynchronous reset mid-division: immediate reset values, nothing resumes.
  task automatic test_reset_mid_div();
    cfg_write(0, 0, 640, 360, 1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    model_cur        = reset_commit();
    model_pend_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    total++;
    if (busy !== 1'b0 || cfg_pending !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_idle: busy=%0b pending=%0b after reset, required 0 0", busy, cfg_pending);
    end
    vs_edge("rst_mid_frame");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unity();
    test_invalid();
    test_vs_mid_div();
    test_back_to_back();
    test_reset_mid_div();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
